// File: rtl/sd_bit_timer.sv
// ---------------------------------------------------------------------------
// sd_bit_timer
//
// Purpose:
//   Generates an SD card clock (sd_clk) by dividing the system clock, and
//   produces single-cycle strobes marking the sample point (sd_clk rising)
//   and the drive point (sd_clk falling) of each serial bit. A bit counter
//   tracks progress through a word and flags the sample that completes it.
//
// Parameters:
//   DIV_W        width of the half-period divider and of div_val
//   CNT_W        width of the bit counter, word_len and bit_cnt
//
// Ports:
//   clk          system clock, all state changes on its rising edge
//   n_rst        asynchronous active-low reset
//   clear        synchronous restart of counters and sd_clk (beats enable)
//   enable       high = timer advances, low = everything frozen
//   div_val      sd_clk half-period in clk cycles (0 behaves as 1)
//   word_len     bits per word (0 behaves as 1)
//   sd_clk       generated SD clock, registered, idles high
//   shift_enable one-cycle pulse in the first cycle sd_clk reads 1
//   drive_enable one-cycle pulse in the first cycle sd_clk reads 0
//   word_done    pulses together with the shift_enable that ends a word
//   bit_cnt      bits sampled so far in the current word
//   busy         high while the generator may toggle sd_clk
//
// Build option:
//   SD_BIT_TIMER_AUTOSTOP_EN  when defined, the timer stops itself after
//   one word (busy drops with word_done, sd_clk parks high) until clear.
//   When undefined, busy stays high and the timer free-runs.
// ---------------------------------------------------------------------------
module sd_bit_timer #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_val,
    input  logic [CNT_W-1:0] word_len,
    output logic             sd_clk,
    output logic             shift_enable,
    output logic             drive_enable,
    output logic             word_done,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             busy
);

    // Internal divider state and terminal values.
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] half_last;
    logic [CNT_W-1:0] bit_last;
    logic             half_done;
    logic             word_end;
    logic             run;

    // Next-state signals.
    logic [DIV_W-1:0] div_cnt_nxt;
    logic [CNT_W-1:0] bit_cnt_nxt;
    logic             sd_clk_nxt;
    logic             shift_nxt;
    logic             drive_nxt;
    logic             word_done_nxt;
    logic             busy_nxt;

    // Terminal counts are H-1 and L-1; a zero setting is treated as one,
    // which makes the terminal count zero (toggle / wrap every time).
    always_comb begin
        half_last = '0;
        bit_last  = '0;
        if (div_val != '0) begin
            half_last = div_val - DIV_W'(1);
        end
        if (word_len != '0) begin
            bit_last = word_len - CNT_W'(1);
        end
    end

    // Using >= rather than == means a setting lowered below the current
    // count still terminates at the next compare instead of wrapping the
    // counter all the way round.
    assign half_done = (div_cnt >= half_last);
    assign word_end  = (bit_cnt >= bit_last);
    assign run       = enable & busy;

    // Next-state computation. Pulses default low so they only ever last one
    // cycle; counters and sd_clk default to holding, which gives the freeze
    // behaviour when enable is low or the timer has stopped itself.
    always_comb begin
        div_cnt_nxt   = div_cnt;
        bit_cnt_nxt   = bit_cnt;
        sd_clk_nxt    = sd_clk;
        busy_nxt      = busy;
        shift_nxt     = 1'b0;
        drive_nxt     = 1'b0;
        word_done_nxt = 1'b0;

        if (clear) begin
            div_cnt_nxt = '0;
            bit_cnt_nxt = '0;
            sd_clk_nxt  = 1'b1;
            busy_nxt    = 1'b1;
        end else if (run) begin
            if (half_done) begin
                div_cnt_nxt = '0;
                sd_clk_nxt  = ~sd_clk;
                if (sd_clk) begin
                    // High to low: drive point.
                    drive_nxt = 1'b1;
                end else begin
                    // Low to high: sample point, one more bit of the word.
                    shift_nxt = 1'b1;
                    if (word_end) begin
                        bit_cnt_nxt   = '0;
                        word_done_nxt = 1'b1;
`ifdef SD_BIT_TIMER_AUTOSTOP_EN
                        // Park with sd_clk high (it is rising on this edge)
                        // and the divider at zero until the next clear.
                        busy_nxt = 1'b0;
`endif
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
            end else begin
                div_cnt_nxt = div_cnt + DIV_W'(1);
            end
        end
    end

    // State and output registers. Every output comes straight from a flop,
    // so there is no combinational path from any input to any output.
    // Reset idles the SD clock high so that the first toggle is a fall.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            sd_clk       <= 1'b1;
            busy         <= 1'b1;
            shift_enable <= 1'b0;
            drive_enable <= 1'b0;
            word_done    <= 1'b0;
        end else begin
            div_cnt      <= div_cnt_nxt;
            bit_cnt      <= bit_cnt_nxt;
            sd_clk       <= sd_clk_nxt;
            busy         <= busy_nxt;
            shift_enable <= shift_nxt;
            drive_enable <= drive_nxt;
            word_done    <= word_done_nxt;
        end
    end

endmodule
